// File: rtl/usb_tx_sie.sv
// usb_tx_sie: full-speed USB transmit serial interface engine.
// Frames builder bytes, buffers them, then bit-stuffs, NRZI-encodes and ends with EOP.
module usb_tx_sie #(
    parameter int CLK_DIV = 4,
    parameter int FIFO_AW = 6
) (
    input  logic       c,
    input  logic       rst_n,
    input  logic [7:0] sie_d,
    input  logic       sie_dv,
    output logic       oe,
    output logic       dp,
    output logic       dm,
    output logic       busy,
    output logic       overflow
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        BITS,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t state, state_n;

    logic [7:0]         pend_d;
    logic               pend_v;
    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, wr_en, pop;
    logic [8:0]         rd_data;

    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    sr, sr_n;
    logic [2:0]    bidx, bidx_n;
    logic [2:0]    ones, ones_n, ones_b;
    logic          lst, lst_n, ebit, ebit_n;
    logic          oe_n, dp_n, dm_n;
    logic          launch, nb, lvl;

    assign full    = count[FIFO_AW];
    assign empty   = (count == '0);
    assign wr_en   = pend_v && !full;
    assign rd_data = mem[rd_ptr];
    assign busy    = !empty || (state != IDLE);

    // Pending byte: a dv run is only known to have ended once dv drops
    always_ff @(posedge c) begin
        if (!rst_n) begin
            pend_v <= 1'b0;
            pend_d <= '0;
        end else begin
            pend_v <= sie_dv;
            if (sie_dv) pend_d <= sie_d;
        end
    end

    // FIFO storage; entry is {last, byte}, last set when dv has dropped
    always_ff @(posedge c) begin
        if (wr_en) mem[wr_ptr] <= {!sie_dv, pend_d};
    end

    // FIFO pointers, fill level and drop pulse
    always_ff @(posedge c) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= pend_v && full;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

    // Serializer state and registered line outputs
    always_ff @(posedge c) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            bidx  <= '0;
            ones  <= '0;
            lst   <= 1'b0;
            ebit  <= 1'b0;
            oe    <= 1'b0;
            dp    <= 1'b1;
            dm    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            bidx  <= bidx_n;
            ones  <= ones_n;
            lst   <= lst_n;
            ebit  <= ebit_n;
            oe    <= oe_n;
            dp    <= dp_n;
            dm    <= dm_n;
        end
    end

    // Next state: bit timing, stuffing, byte chaining and EOP sequencing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        bidx_n  = bidx;
        lst_n   = lst;
        ebit_n  = ebit;
        ones_b  = ones;
        ones_n  = ones;
        oe_n    = oe;
        dp_n    = dp;
        dm_n    = dm;
        pop     = 1'b0;
        launch  = 1'b0;
        nb      = 1'b0;
        lvl     = dp;
        unique case (state)
            IDLE: begin
                oe_n = 1'b0;
                dp_n = 1'b1;
                dm_n = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    sr_n    = rd_data[7:0];
                    lst_n   = rd_data[8];
                    bidx_n  = '0;
                    cnt_n   = '0;
                    ones_b  = '0;
                    lvl     = 1'b1;
                    nb      = rd_data[0];
                    launch  = 1'b1;
                    oe_n    = 1'b1;
                    state_n = BITS;
                end
            end
            BITS: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (ones == 3'd6) begin
                        dp_n   = ~dp;
                        dm_n   = dp;
                        ones_n = '0;
                    end else if (bidx != 3'd7) begin
                        bidx_n = bidx + 3'd1;
                        nb     = sr[bidx_n];
                        launch = 1'b1;
                    end else if (!lst && !empty) begin
                        pop    = 1'b1;
                        sr_n   = rd_data[7:0];
                        lst_n  = rd_data[8];
                        bidx_n = '0;
                        nb     = rd_data[0];
                        launch = 1'b1;
                    end else begin
                        // a lost last flag leaves an unterminated run;
                        // close it once the buffer runs dry
                        state_n = EOP_SE0;
                        ebit_n  = 1'b0;
                        dp_n    = 1'b0;
                        dm_n    = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            EOP_SE0: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (ebit) begin
                        state_n = EOP_J;
                        dp_n    = 1'b1;
                        dm_n    = 1'b0;
                    end else begin
                        ebit_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            EOP_J: begin
                if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (launch) begin
            if (nb) begin
                ones_n = ones_b + 3'd1;
                dp_n   = lvl;
                dm_n   = ~lvl;
            end else begin
                ones_n = '0;
                dp_n   = ~lvl;
                dm_n   = lvl;
            end
        end
    end

endmodule
